// File: rtl/fp8_result_decoder.sv
// -----------------------------------------------------------------------------
// fp8_result_decoder
//
// Converts 8-bit MAC result beats into signed int8 for the result writer.
// A beat is either a 1-4-3 fp8 value (sign, 4-bit exponent, 3-bit mantissa)
// or an int8 that passes through unchanged; the choice is made per beat by
// in_float. Beats flow through a two-stage elastic pipeline (unpack, then
// shift/saturate) into a small output FIFO. A running count is kept of results
// that had to be clamped to the int8 range.
//
// Optional build macro:
//   FP8_ROUND_EN  - right shifts round to nearest, ties away from zero.
//                   When undefined, right shifts truncate toward zero.
//
// Parameters:
//   EXP_BIAS    fp8 exponent bias (value = (-1)^s * 1.mmm * 2^(e-EXP_BIAS))
//   FIFO_DEPTH  output FIFO entries, power of two, >= 2
//   CNT_W       width of sat_count
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_data/in_float    input beat and its format select
//   in_valid/in_ready   input handshake
//   out_data/out_sat    FIFO head: decoded int8 and its saturation flag
//   out_valid/out_ready output handshake (out_valid = FIFO not empty)
//   clear_stats         synchronous clear of sat_count
//   sat_count           saturated results written to the FIFO (sticks at max)
//   fifo_count          current FIFO occupancy
// -----------------------------------------------------------------------------
module fp8_result_decoder #(
  parameter int EXP_BIAS   = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_float,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [7:0]             out_data,
  output logic                          out_sat,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          clear_stats,
  output logic [CNT_W-1:0]              sat_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Shift distance from the integer {1,mmm} to the real magnitude: the
  // mantissa carries three fraction bits on top of the exponent bias.
  localparam logic [5:0] SH_OFS = 6'(EXP_BIAS + 3);

  typedef struct packed {
    logic       sat;
    logic [7:0] data;
  } fifo_entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // S1: unpacked fields of the accepted beat
  logic        s1_v_q,     s1_v_d;
  logic        s1_sign_q,  s1_sign_d;
  logic [3:0]  s1_exp_q,   s1_exp_d;
  logic [3:0]  s1_mant_q,  s1_mant_d;   // {1, mmm}
  logic        s1_float_q, s1_float_d;
  logic [7:0]  s1_raw_q,   s1_raw_d;

  // S2: decoded result waiting for a FIFO slot
  logic        s2_v_q,     s2_v_d;
  logic [7:0]  s2_data_q,  s2_data_d;
  logic        s2_sat_q,   s2_sat_d;

  // FIFO: pointers carry one extra wrap bit so full and empty differ
  fifo_entry_t             fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]             wr_ptr_q,  wr_ptr_d;
  logic [AW:0]             rd_ptr_q,  rd_ptr_d;

  logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;

  // ---------------------------------------------------------------------------
  // Handshake and pipeline advance
  // ---------------------------------------------------------------------------
  logic        fifo_full;
  logic        fifo_pop;
  logic        fifo_push;
  logic        fifo_wr_ok;
  logic        s1_adv;
  logic        s2_adv;
  logic        in_fire;
  fifo_entry_t fifo_head;

  always_comb begin : handshake
    fifo_count = wr_ptr_q - rd_ptr_q;
    fifo_full  = (fifo_count == (AW + 1)'(FIFO_DEPTH));
    out_valid  = (fifo_count != '0);
    fifo_pop   = out_valid & out_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    fifo_wr_ok = ~fifo_full | fifo_pop;
    s2_adv     = ~s2_v_q | fifo_wr_ok;
    fifo_push  = s2_v_q & fifo_wr_ok;
    s1_adv     = ~s1_v_q | s2_adv;
    // Reset is folded in so no beat is offered a handshake while it is held.
    in_ready   = s1_adv & ~rst;
    in_fire    = in_valid & in_ready;
  end

  // ---------------------------------------------------------------------------
  // S2 datapath: shift and saturate the S1 fields
  // ---------------------------------------------------------------------------
  logic [5:0]  sh;        // e - EXP_BIAS - 3, two's complement
  logic [5:0]  rsh;       // -sh, right-shift distance when sh < 0
  logic [11:0] mag;
  logic [7:0]  dec_data;
  logic        dec_sat;
`ifdef FP8_ROUND_EN
  logic [1:0]  rnd_idx;   // bit of {1,mmm} just below the kept part
`endif

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin : decode
    dec_data = 8'h00;
    dec_sat  = 1'b0;
    mag      = '0;
    sh       = {2'b00, s1_exp_q} - SH_OFS;
    rsh      = 6'd0 - sh;
`ifdef FP8_ROUND_EN
    rnd_idx  = rsh[1:0] - 2'd1;
`endif

    if (!s1_float_q) begin
      dec_data = s1_raw_q;
    end else if (s1_exp_q != 4'd0) begin
      if (!sh[5]) begin
        // Left shift; anything of 8 or more is far past int8 range.
        if (sh[4:3] != 2'b00) begin
          mag = '1;
        end else begin
          mag = {8'h00, s1_mant_q} << sh[2:0];
        end
      end else if (rsh > 6'd4) begin
        // All of {1,mmm} and its rounding bit fall below the binary point.
        mag = '0;
      end else begin
        mag = {8'h00, s1_mant_q >> rsh[2:0]};
`ifdef FP8_ROUND_EN
        // Adding the first discarded bit of the magnitude rounds half away
        // from zero once the sign is reapplied.
        mag = mag + {11'd0, s1_mant_q[rnd_idx]};
`endif
      end

      // Negative side reaches one further than positive (-128 vs 127).
      if (!s1_sign_q) begin
        if (mag > 12'd127) begin
          dec_data = 8'h7F;
          dec_sat  = 1'b1;
        end else begin
          dec_data = mag[7:0];
        end
      end else begin
        if (mag > 12'd128) begin
          dec_data = 8'h80;
          dec_sat  = 1'b1;
        end else begin
          dec_data = 8'h00 - mag[7:0];
        end
      end
    end
    // e == 0 flushes to zero with no saturation (defaults above).
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    s1_v_d     = s1_v_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_float_d = s1_float_q;
    s1_raw_d   = s1_raw_q;
    s2_v_d     = s2_v_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sat_cnt_d  = sat_cnt_q;

    if (s1_adv) begin
      s1_v_d = in_fire;
      if (in_fire) begin
        s1_sign_d  = in_data[7];
        s1_exp_d   = in_data[6:3];
        s1_mant_d  = {1'b1, in_data[2:0]};
        s1_float_d = in_float;
        s1_raw_d   = in_data;
      end
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_data_d = dec_data;
        s2_sat_d  = dec_sat;
      end
    end

    if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    // Clear takes priority over a same-cycle increment.
    if (clear_stats) begin
      sat_cnt_d = '0;
    end else if (fifo_push && s2_sat_q && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_float_q <= 1'b0;
      s1_raw_q   <= '0;
      s2_v_q     <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s1_float_q <= s1_float_d;
      s1_raw_q   <= s1_raw_d;
      s2_v_q     <= s2_v_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers alone define which
  // entries are live, and the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= '{sat: s2_sat_q, data: s2_data_q};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin : outputs
    fifo_head = fifo_mem_q[rd_ptr_q[AW-1:0]];
    out_data  = 8'sh00;
    out_sat   = 1'b0;
    if (out_valid) begin
      out_data = fifo_head.data;
      out_sat  = fifo_head.sat;
    end
    sat_count = sat_cnt_q;
  end

endmodule

// File: tb/tb_fp8_result_decoder.sv
// -----------------------------------------------------------------------------
// tb_fp8_result_decoder
//
// Scoreboard bench for fp8_result_decoder. Each accepted input beat pushes its
// expected {sat, data} from an arithmetic reference model into a queue; an
// independent monitor pops and compares whenever the DUT hands out a result.
// -----------------------------------------------------------------------------
module tb_fp8_result_decoder;

  localparam int EXP_BIAS   = 7;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [7:0]                  in_data;
  logic                        in_float;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [7:0]           out_data;
  logic                        out_sat;
  logic                        out_valid;
  logic                        out_ready;
  logic                        clear_stats;
  logic [CNT_W-1:0]            sat_count;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;
  int exp_sat_cnt = 0;
  logic [8:0] sb [$];

  fp8_result_decoder #(
    .EXP_BIAS  (EXP_BIAS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_float   (in_float),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clear_stats(clear_stats),
    .sat_count  (sat_count),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: real value = (8+m)/8 * 2^(e-bias), scaled to an integer, then
  // clamped into [-128, 127].
  function automatic logic [8:0] model(input logic [7:0] d, input logic f);
    int e, num, p, div, mag, v;
    if (!f) return {1'b0, d};
    e   = int'(d[6:3]);
    num = 8 + int'(d[2:0]);
    if (e == 0) return 9'h000;
    p = e - EXP_BIAS - 3;
    if (p >= 0) begin
      mag = num * (1 << p);
    end else begin
      div = 1 << (-p);
`ifdef FP8_ROUND_EN
      mag = (num + div / 2) / div;
`else
      mag = num / div;
`endif
    end
    v = d[7] ? -mag : mag;
    if (v > 127)  return {1'b1, 8'h7F};
    if (v < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(v)};
  endfunction

  task automatic expect_beat(input logic [7:0] d, input logic f);
    logic [8:0] e;
    e = model(d, f);
    sb.push_back(e);
    if (e[8]) exp_sat_cnt++;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [7:0] d, input logic f);
    int n;
    n = 0;
    in_data  = d;
    in_float = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", {31'd0, in_ready}, 32'd1);
    expect_beat(d, f);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    check("drain_fifo_count", {29'd0, fifo_count}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each result the consumer takes against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h, expected no output (t=%0t)",
                 {out_sat, out_data}, $time);
      end else begin
        check("out_beat", {23'd0, out_sat, out_data}, {23'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp_beats [8];
    int idx;
    int acc;

    rst         = 1'b1;
    in_data     = '0;
    in_float    = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    clear_stats = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_in_ready",   {31'd0, in_ready},   32'd0);
    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_out",        {23'd0, out_sat, out_data}, 32'd0);
    check("rst_sat_count",  {16'd0, sat_count},  32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // ---------------- directed decode vectors ----------------
    send(8'h3C, 1'b1);
    send(8'h50, 1'b1);
    send(8'hD0, 1'b1);
    send(8'h38, 1'b1);
    send(8'h30, 1'b1);
    send(8'h7F, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h85, 1'b0);
    send(8'h05, 1'b1);
    send(8'hC0, 1'b1);   // -1.0 * 2^1 at e=8 -> -2 (truncation/round agree)
    send(8'hF8, 1'b1);   // large negative -> clamps
    send(8'hD8, 1'b1);   // e=11, -16 region: no saturation
    drain();
    check("sat_count_directed", {16'd0, sat_count}, 32'(exp_sat_cnt));

    // ---------------- clear_stats vs same-cycle saturated push ----------------
    in_data  = 8'h7F;
    in_float = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("clr_accept", {31'd0, in_ready}, 32'd1);
    expect_beat(8'h7F, 1'b1);
    @(posedge clk);            // E0: accepted
    #1;
    in_valid = 1'b0;
    @(posedge clk);            // E1: in S2
    #1;
    clear_stats = 1'b1;
    @(posedge clk);            // E2: pushed to FIFO together with the clear
    #1;
    clear_stats = 1'b0;
    exp_sat_cnt = 0;
    @(negedge clk);
    check("clear_wins", {16'd0, sat_count}, 32'd0);
    drain();

    // ---------------- backpressure: 8 beats against a stalled consumer ----------------
    for (int i = 0; i < 8; i++) bp_beats[i] = 8'($urandom);
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 8);
      in_data  = bp_beats[idx % 8];
      in_float = 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) begin
        expect_beat(bp_beats[idx], 1'b1);
        idx++;
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepts",    32'(acc), 32'd6);
    check("bp_fifo_full",  {29'd0, fifo_count}, 32'(FIFO_DEPTH));
    check("bp_in_ready",   {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && idx < 8; c++) begin
      in_valid = 1'b1;
      in_data  = bp_beats[idx];
      in_float = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        expect_beat(bp_beats[idx], 1'b1);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_all_sent", 32'(idx), 32'd8);
    drain();

    // ---------------- randomized traffic ----------------
    clear_stats = 1'b0;
    exp_sat_cnt = 0;
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_float  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) expect_beat(in_data, in_float);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    check("sat_count_random", {16'd0, sat_count}, 32'(exp_sat_cnt));

    // ---------------- reset with beats in flight ----------------
    out_ready = 1'b0;
    send(8'h7F, 1'b1);
    send(8'h50, 1'b1);
    in_data  = 8'hFF;
    in_float = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);            // third beat accepted; first now in FIFO
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    exp_sat_cnt = 0;
    @(negedge clk);
    check("midrst_out_valid",  {31'd0, out_valid},  32'd0);
    check("midrst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("midrst_sat_count",  {16'd0, sat_count},  32'd0);
    check("midrst_in_ready",   {31'd0, in_ready},   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_ghost", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // ---------------- first-beat latency after reset ----------------
    in_data  = 8'h50;
    in_float = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_accept", {31'd0, in_ready}, 32'd1);
    expect_beat(8'h50, 1'b1);
    @(posedge clk);            // E0
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_after_e0", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_after_e1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_after_e2", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
